mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Purpose  : Shared types and defaults for the fetch/data memory arbiter.
//             Holds the controller state encoding, the owner encoding and
//             the default RAM address/data widths.
//  Revision : 1.0  initial release
// ============================================================================
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  // Controller states: at most one RAM transaction in flight.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Which requester owns the current RAM transaction.
  typedef enum logic [0:0] {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pick
//  Purpose  : Pure combinational winner select between fetch and data
//             requesters. With RR_EN=0 data always wins a collision; with
//             RR_EN=1 the requester not granted last wins. The round-robin
//             pointer itself lives in the parent.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic   f_req_i,
  input  logic   d_req_i,
  input  owner_e last_i,
  output logic   valid_o,
  output owner_e winner_o
);

  logic w_prefer_d;

  // Collision policy and winner select.
  always_comb begin
    w_prefer_d = RR_EN ? (last_i == OWN_F) : 1'b1;
    valid_o    = f_req_i | d_req_i;
    winner_o   = (d_req_i && (!f_req_i || w_prefer_d)) ? OWN_D : OWN_F;
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one RAM port between a fetch unit (read only) and a
//             load/store unit. IDLE arbitrates, CMD holds the command until
//             the RAM accepts it, WAIT collects the read data/completion.
//             Define MEM_ARB_RR_EN for round-robin collision handling;
//             otherwise the data requester has fixed priority.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  // fetch requester
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_cack,
  output logic              f_data_ready,
  output logic [DATA_W-1:0] f_data,
  // load/store requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_cack,
  output logic              d_data_ready,
  output logic [DATA_W-1:0] d_data,
  // shared RAM
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_busy,
  input  logic              ram_cack,
  input  logic              ram_data_ready,
  input  logic [DATA_W-1:0] ram_data
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic              ram_read_q, ram_read_d;
  logic              ram_write_q, ram_write_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] f_data_q, f_data_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;
  logic              f_cack_q, f_cack_d;
  logic              d_cack_q, d_cack_d;
  logic              f_rdy_q, f_rdy_d;
  logic              d_rdy_q, d_rdy_d;

  logic              w_req_any;
  owner_e            w_winner;
  owner_e            w_last;
  logic              w_grant;
  logic              w_accept;
  logic              w_done;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
  owner_e last_q;

  // Round-robin pointer: remembers who received the most recent grant.
  always_ff @(posedge clk) begin
    if (!rst_n)       last_q <= OWN_F;
    else if (w_grant) last_q <= w_winner;
  end

  assign w_last = last_q;
`else
  localparam bit RR_EN = 1'b0;
  assign w_last = OWN_F;
`endif

  mem_arb_pick #(
    .RR_EN (RR_EN)
  ) u_pick (
    .f_req_i  (f_req),
    .d_req_i  (d_req),
    .last_i   (w_last),
    .valid_o  (w_req_any),
    .winner_o (w_winner)
  );

  // A grant only happens from IDLE with the RAM free; completion may coincide with accept.
  assign w_grant  = (state_q == IDLE) && w_req_any && !ram_busy;
  assign w_accept = (state_q == CMD) && ram_cack;
  assign w_done   = ((state_q == CMD) && ram_cack && ram_data_ready) ||
                    ((state_q == WAIT) && ram_data_ready);

  // Next-state, command latch and one-cycle owner pulses.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    ram_read_d  = ram_read_q;
    ram_write_d = ram_write_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    f_data_d    = f_data_q;
    d_data_d    = d_data_q;
    f_cack_d    = 1'b0;
    d_cack_d    = 1'b0;
    f_rdy_d     = 1'b0;
    d_rdy_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (w_grant) begin
          owner_d = w_winner;
          if (w_winner == OWN_D) begin
            ram_addr_d  = d_addr;
            ram_wdata_d = d_wdata;
            we_d        = d_we;
          end else begin
            ram_addr_d  = f_addr;
            ram_wdata_d = '0;
            we_d        = 1'b0;
          end
          ram_read_d  = !we_d;
          ram_write_d = we_d;
          state_d     = CMD;
        end
      end
      CMD: begin
        if (ram_cack) state_d = ram_data_ready ? IDLE : WAIT;
      end
      WAIT: begin
        if (ram_data_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (w_accept) begin
      ram_read_d  = 1'b0;
      ram_write_d = 1'b0;
      f_cack_d    = (owner_q == OWN_F);
      d_cack_d    = (owner_q == OWN_D);
    end

    // Writes signal completion but leave the requester's read data untouched.
    if (w_done) begin
      f_rdy_d = (owner_q == OWN_F);
      d_rdy_d = (owner_q == OWN_D);
      if (!we_q) begin
        if (owner_q == OWN_F) f_data_d = ram_data;
        else                  d_data_d = ram_data;
      end
    end
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_F;
      we_q        <= 1'b0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      f_data_q    <= '0;
      d_data_q    <= '0;
      f_cack_q    <= 1'b0;
      d_cack_q    <= 1'b0;
      f_rdy_q     <= 1'b0;
      d_rdy_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      f_data_q    <= f_data_d;
      d_data_q    <= d_data_d;
      f_cack_q    <= f_cack_d;
      d_cack_q    <= d_cack_d;
      f_rdy_q     <= f_rdy_d;
      d_rdy_q     <= d_rdy_d;
    end
  end

  assign ram_read     = ram_read_q;
  assign ram_write    = ram_write_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign f_cack       = f_cack_q;
  assign d_cack       = d_cack_q;
  assign f_data_ready = f_rdy_q;
  assign d_data_ready = d_rdy_q;
  assign f_data       = f_data_q;
  assign d_data       = d_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Scoreboard bench for mem_arbiter. Stimulus pushes expected RAM
//             commands and per-requester read results (from a transaction-
//             level memory model) into queues; a monitor pops and compares
//             whenever the DUT presents a command, accept or completion.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_cack, f_data_ready;
  logic [DW-1:0] f_data;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_cack, d_data_ready;
  logic [DW-1:0] d_data;
  logic          ram_read, ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_busy = 1'b0, ram_cack, ram_data_ready;
  logic [DW-1:0] ram_data;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_cack(f_cack),
    .f_data_ready(f_data_ready), .f_data(f_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_cack(d_cack), .d_data_ready(d_data_ready), .d_data(d_data),
    .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_busy(ram_busy), .ram_cack(ram_cack),
    .ram_data_ready(ram_data_ready), .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          own;   // 0 = fetch, 1 = data
  } cmd_t;

  cmd_t          exp_cmd_q[$];
  logic [DW-1:0] exp_f_q[$];
  logic [DW-1:0] exp_d_q[$];
  logic [DW-1:0] ram_mem[int];
  logic [DW-1:0] shadow[int];
  logic [DW-1:0] m_f_last = '0;
  logic [DW-1:0] m_d_last = '0;
  logic          m_last = 1'b0;   // who was granted last (model)
  int            f_done = 0;
  int            d_done = 0;
  logic          b2b_armed = 1'b0;
  int            last_done_cyc = -100;

  // responder configuration
  logic          rnd_mode = 1'b0;
  int            cack_dly = 0;
  int            dr_dly = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    return 32'hC0DE0000 ^ a;
  endfunction

  // Transaction-level model: one grant applied to the shadow memory.
  task automatic model_grant(input logic own, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] wd);
    cmd_t c;
    int key;
    logic [DW-1:0] rd;
    key     = int'(a);
    c.we    = we;
    c.addr  = a;
    c.wdata = wd;
    c.own   = own;
    exp_cmd_q.push_back(c);
    if (we) begin
      shadow[key] = wd;
    end else begin
      rd = shadow.exists(key) ? shadow[key] : init_val(key);
      if (own) m_d_last = rd;
      else     m_f_last = rd;
    end
    if (own) exp_d_q.push_back(m_d_last);
    else     exp_f_q.push_back(m_f_last);
    m_last = own;
  endtask

  // RAM responder with its own storage and configurable latencies.
  int            rs_cd, rs_dd, rs_addr;
  logic          rs_we;
  logic [DW-1:0] rs_wd;
  initial begin
    ram_cack = 1'b0;
    ram_data_ready = 1'b0;
    ram_data = '0;
    forever begin
      @(negedge clk);
      if ((ram_read || ram_write) && rst_n) begin
        rs_cd   = rnd_mode ? int'($urandom_range(0, 3)) : cack_dly;
        rs_dd   = rnd_mode ? int'($urandom_range(0, 3)) : dr_dly;
        rs_we   = ram_write;
        rs_addr = int'(ram_addr);
        rs_wd   = ram_wdata;
        repeat (rs_cd) @(negedge clk);
        ram_cack = 1'b1;
        if (rs_dd == 0) begin
          ram_data_ready = 1'b1;
          ram_data = rs_we ? $urandom : (ram_mem.exists(rs_addr) ? ram_mem[rs_addr] : init_val(rs_addr));
        end
        @(negedge clk);
        ram_cack = 1'b0;
        ram_data_ready = 1'b0;
        if (rs_dd > 0) begin
          repeat (rs_dd - 1) @(negedge clk);
          ram_data_ready = 1'b1;
          ram_data = rs_we ? $urandom : (ram_mem.exists(rs_addr) ? ram_mem[rs_addr] : init_val(rs_addr));
          @(negedge clk);
          ram_data_ready = 1'b0;
        end
        if (rs_we) ram_mem[rs_addr] = rs_wd;
      end
    end
  end

  // Monitor: compares every DUT-presented command, accept and completion.
  logic prev_cmd = 1'b0;
  logic cur_valid = 1'b0;
  cmd_t cur;
  int   cacks_seen = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cmd  = 1'b0;
        cur_valid = 1'b0;
        continue;
      end
      if ((ram_read || ram_write) && !prev_cmd) begin
        if (exp_cmd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_cmd: actual rd=%0b wr=%0b addr=%0h required none", ram_read, ram_write, ram_addr);
        end else begin
          cur = exp_cmd_q.pop_front();
          cur_valid = 1'b1;
          cacks_seen = 0;
          chk("cmd_kind", {ram_write, ram_read}, {cur.we, !cur.we});
          chk("cmd_addr", ram_addr, cur.addr);
          if (cur.we) chk("cmd_wdata", ram_wdata, cur.wdata);
        end
        if (b2b_armed) begin
          chk("b2b_turnaround", cyc - last_done_cyc, 1);
          b2b_armed = 1'b0;
        end
      end else if ((ram_read || ram_write) && cur_valid) begin
        chk("cmd_hold_addr", ram_addr, cur.addr);
      end
      prev_cmd = ram_read | ram_write;

      if (f_cack || d_cack) begin
        chk("cack_owner", {f_cack, d_cack}, cur_valid ? (cur.own ? 2'b01 : 2'b10) : 2'b00);
        chk("cack_once", cacks_seen, 0);
        cacks_seen++;
      end
      if (f_data_ready) begin
        f_done++;
        last_done_cyc = cyc;
        if (exp_f_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_f_data_ready: actual pulse required none");
        end else begin
          chk("f_data", f_data, exp_f_q.pop_front());
        end
      end
      if (d_data_ready) begin
        d_done++;
        last_done_cyc = cyc;
        if (exp_d_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_d_data_ready: actual pulse required none");
        end else begin
          chk("d_data", d_data, exp_d_q.pop_front());
        end
      end
    end
  end

  // One round: optional fetch and/or data request raised in the same cycle.
  task automatic run_round(input logic fg, input logic dg, input logic dwe,
                           input logic [AW-1:0] fa, input logic [AW-1:0] da,
                           input logic [DW-1:0] dwd, input int busy_cyc, input logic early);
    int   tf;
    int   td;
    int   n;
    logic first_seen;
    logic d_first;
    tf = f_done + int'(fg);
    td = d_done + int'(dg);
    first_seen = 1'b0;
    if (fg && dg) begin
`ifdef MEM_ARB_RR_EN
      d_first = (m_last == 1'b0);
`else
      d_first = 1'b1;
`endif
      if (d_first) begin
        model_grant(1'b1, dwe, da, dwd);
        model_grant(1'b0, 1'b0, fa, '0);
      end else begin
        model_grant(1'b0, 1'b0, fa, '0);
        model_grant(1'b1, dwe, da, dwd);
      end
    end else if (fg) begin
      model_grant(1'b0, 1'b0, fa, '0);
    end else if (dg) begin
      model_grant(1'b1, dwe, da, dwd);
    end
    f_addr = fa; d_addr = da; d_we = dwe; d_wdata = dwd;
    f_req = fg; d_req = dg;
    if (busy_cyc > 0) begin
      ram_busy = 1'b1;
      repeat (busy_cyc) begin
        @(negedge clk);
        chk("busy_stall", {ram_read, ram_write}, 2'b00);
      end
      ram_busy = 1'b0;
      @(negedge clk);
      chk("busy_release", ram_read | ram_write, 1'b1);
    end
    n = 0;
    while ((f_done < tf || d_done < td || f_req || d_req) && n < 200) begin
      @(negedge clk);
      n++;
      if (f_req && f_cack) begin
        f_req = 1'b0;
        if (fg && dg && !first_seen) begin first_seen = 1'b1; b2b_armed = 1'b1; end
      end
      if (d_req && d_cack) begin
        d_req = 1'b0;
        if (fg && dg && !first_seen) begin first_seen = 1'b1; b2b_armed = 1'b1; end
      end
      if (early && d_req && ram_read && !d_cack) d_req = 1'b0;
    end
    chk("round_complete", {f_done >= tf, d_done >= td}, 2'b11);
    f_req = 1'b0;
    d_req = 1'b0;
  endtask

  int f_before;
  int n_wait;

  initial begin
    ram_mem[16'h0040] = 32'hDEADBEEF;
    shadow[16'h0040]  = 32'hDEADBEEF;

    // reset values
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_f_cack", f_cack, 0);
    chk("rst_f_rdy", f_data_ready, 0);
    chk("rst_f_data", f_data, 0);
    chk("rst_d_cack", d_cack, 0);
    chk("rst_d_rdy", d_data_ready, 0);
    chk("rst_d_data", d_data, 0);
    chk("rst_ram_read", ram_read, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single fetch read, cack after 2 cycles, data 3 cycles later
    cack_dly = 2; dr_dly = 3;
    run_round(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, '0, 0, 1'b0);
    chk("single_fetch_data", f_data, 32'hDEADBEEF);
    chk("single_fetch_d_quiet", d_data, 0);
    @(negedge clk);

    // collision: data write to 0x1000 goes before the fetch read of 0x1000
    cack_dly = 1; dr_dly = 1;
    run_round(1'b1, 1'b1, 1'b1, 16'h1000, 16'h1000, 32'h0000ABCD, 0, 1'b0);
    chk("collision_fetch_sees_write", f_data, 32'h0000ABCD);
    @(negedge clk);

    // RAM busy stalls arbitration for 5 cycles
    run_round(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0040, '0, 5, 1'b0);
    @(negedge clk);

    // accept and completion in the same cycle
    cack_dly = 1; dr_dly = 0;
    run_round(1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, '0, 0, 1'b0);
    @(negedge clk);

    // data requester drops its request while the command is still pending
    cack_dly = 3; dr_dly = 2;
    run_round(1'b0, 1'b1, 1'b0, 16'h0000, 16'h1000, '0, 0, 1'b1);
    chk("early_drop_data", d_data, 32'h0000ABCD);
    @(negedge clk);

    // reset while waiting for completion; the late data_ready is stale
    cack_dly = 0; dr_dly = 6;
    model_grant(1'b0, 1'b0, 16'h0040, '0);
    f_addr = 16'h0040; f_req = 1'b1;
    n_wait = 0;
    while (!f_cack && n_wait < 50) begin @(negedge clk); n_wait++; end
    chk("rst_wait_cack_seen", f_cack, 1);
    f_req = 1'b0;
    f_before = f_done;
    @(negedge clk);
    rst_n = 1'b0;
    exp_cmd_q.delete(); exp_f_q.delete(); exp_d_q.delete();
    m_f_last = '0; m_d_last = '0; m_last = 1'b0; b2b_armed = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("stale_ready_ignored", f_done, f_before);
    chk("post_rst_f_data", f_data, 0);
    chk("post_rst_d_data", d_data, 0);
    chk("post_rst_ram_cmd", {ram_read, ram_write}, 2'b00);
    chk("post_rst_ram_addr", ram_addr, 0);
    run_round(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, '0, 0, 1'b0);
    chk("post_rst_fetch", f_data, 32'hDEADBEEF);

    // randomized traffic
    rnd_mode = 1'b1;
    for (int i = 0; i < 80; i++) begin
      logic          fg, dg, dwe, early;
      int            pat, busy;
      pat   = int'($urandom_range(0, 2));
      fg    = (pat != 1);
      dg    = (pat != 0);
      dwe   = $urandom_range(0, 1) == 1;
      busy  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      early = dg && !fg && !dwe && ($urandom_range(0, 3) == 0);
      run_round(fg, dg, dwe, AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                $urandom, busy, early);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("queues_drained", exp_cmd_q.size() + exp_f_q.size() + exp_d_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
